sr_cmd_gen: RTL
===============

Name: sr_cmd_gen

Overview:
Upstream command stage for the SR flip-flop. It takes two raw, asynchronous request lines (set and clear, e.g. pushbuttons or external strobes) and turns them into clean, registered, single-cycle S and R pulses. S and R are never high in the same cycle, so the flip-flop's forbidden 11 input cannot occur. It also flags request conflicts and spaces consecutive commands by a hold-off window.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive cycles the synchronized input must hold a new level before that level is accepted (min 2)
HOLDOFF_CYCLES, 4, minimum idle cycles after any emitted pulse before the next pulse (min 1)
R_PRIORITY, 1, on simultaneous requests: 1 = clear (R) wins, 0 = set (S) wins

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
set_req_raw  input  1  raw asynchronous set request, active-high
clr_req_raw  input  1  raw asynchronous clear request, active-high
S  output  1  single-cycle set pulse to SR flip-flop
R  output  1  single-cycle clear pulse to SR flip-flop
conflict  output  1  single-cycle pulse: both requests became valid in the same cycle
busy  output  1  high while in hold-off or while a request is pending

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: S=0, R=0, conflict=0, busy=0; synchronizers, debounce stable values, counters, pending flags and FSM all cleared. FSM state is IDLE.
- Synchronizer: each raw input passes through 2 flops, and nothing downstream uses the raw inputs.
- Debounce (per input):
  - The counter clears whenever the synced value equals the stable value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the stable value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Request: a 0->1 transition of a stable value sets that side's pending flag, registered.
  - Falling edges generate nothing.
  - A pending flag already set absorbs repeats; it is one-deep.
- Latency: if raw rises and stays high, the S/R pulse begins exactly DEBOUNCE_CYCLES+4 clock edges after the first edge that samples raw=1, provided the FSM is IDLE.
- FSM states:
  - IDLE: if any pending flag is set, go to FIRE and select a side.
    - Only one flag set: select that side.
    - Both set: select per R_PRIORITY and keep the losing side's flag.
  - FIRE (1 cycle): drive exactly one of S or R high, clear the selected pending flag, go to HOLD.
  - HOLD: count HOLDOFF_CYCLES cycles with S=R=0, then go to IDLE. Pending flags keep accumulating during HOLD.
- conflict pulses in the cycle both pending flags are first simultaneously set from the IDLE-visible state; it is asserted together with the FIRE selection.
- busy = (state != IDLE) OR any pending flag.
- Simultaneous stable rising edges on both sides set both flags in the same cycle. The priority side fires first; the other side fires after hold-off, so both commands execute in order.
- Reset mid-debounce or mid-HOLD aborts everything; no pulse is emitted after rst deasserts unless the inputs re-qualify.
- Invariant: S & R == 0 in every cycle.

Optional Feature:
SR_CONFLICT_CNT_EN
- Defined: adds output conflict_cnt [7:0], a saturating count of conflict pulses. It holds at 255, resets to 0 on rst, and has no other effect on behaviour.
- Undefined: the port and the counter do not exist.

Decomposition:
- Package sr_cmd_pkg:
  - FSM state typedef enum {IDLE, FIRE, HOLD}.
  - Constants SEL_S=1'b0, SEL_R=1'b1.
  - Function for counter width, clog2 of the parameter.
- Sub-module sr_debounce (2-flop sync, debounce counter, rising-edge output): instantiated twice, once per request line.

Test Plan:
- Reset: assert rst mid-operation with a pending set → all outputs 0 immediately and asynchronously; no S pulse after release.
- Clean set: set_req_raw held high for 40 cycles, DEBOUNCE_CYCLES=16 → S high exactly 1 cycle at edge 20, R never asserted, busy high until HOLD ends.
- Glitch: clr_req_raw high for 10 cycles then low → no R pulse, busy stays 0.
- Simultaneous: both raw inputs rise on the same edge, R_PRIORITY=1 → R pulse at edge 20, conflict at edge 20, S pulse at edge 25 (HOLDOFF_CYCLES=4).
- Hold-off accumulation: second set qualifies during HOLD → S fires the cycle after HOLD exits; three qualifying sets within one HOLD → only one extra S.
- With SR_CONFLICT_CNT_EN: 300 conflict events → conflict_cnt saturates at 255. Check S&R==0 in every cycle of every test.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and helpers for the SR command generator.
// No logic of its own; zero latency.
// No flow control; pure declarations.
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic SEL_S = 1'b0;
    localparam logic SEL_R = 1'b1;

    // Bits needed for a counter whose largest value is n-1 (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer plus debounce filter; emits a one-cycle pulse on an accepted 0->1 level.
// rise is registered: it fires DEBOUNCE_CYCLES+1 edges after the first edge that samples din=1.
// No backpressure; a new level must hold DEBOUNCE_CYCLES consecutive cycles to be accepted.
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has been seen DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
                rise   <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns raw set/clear requests into registered, mutually exclusive single-cycle S/R pulses.
// Pulse starts DEBOUNCE_CYCLES+4 edges after raw is first sampled high (FSM idle).
// No backpressure; one-deep pending flag per side, pulses spaced by HOLDOFF_CYCLES idle cycles.
// Optional SR_CONFLICT_CNT_EN adds conflict_cnt, a saturating 8-bit conflict counter.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 4,
    parameter int R_PRIORITY      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req_raw,
    input  logic       clr_req_raw,
    output logic       S,
    output logic       R,
    output logic       conflict,
    output logic       busy
`ifdef SR_CONFLICT_CNT_EN
    ,
    output logic [7:0] conflict_cnt
`endif
);

    // S/R are registered one cycle after FIRE, and that register stage already
    // contributes one idle output cycle, so HOLD itself lasts HOLDOFF_CYCLES-1
    // cycles to make the pulse-to-pulse gap exactly HOLDOFF_CYCLES.
    localparam int HW = cnt_width(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 2 : 0);
    localparam logic PRIO_SEL = (R_PRIORITY != 0) ? SEL_R : SEL_S;

    logic          set_rise;
    logic          clr_rise;
    logic          pend_s;
    logic          pend_r;
    logic          clr_s;
    logic          clr_r;
    state_t        state_q;
    state_t        state_d;
    logic          sel_q;
    logic          sel_d;
    logic          conf_q;
    logic          conf_d;
    logic          s_d;
    logic          r_d;
    logic          conflict_d;
    logic [HW-1:0] hold_cnt;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk  (clk),
        .rst  (rst),
        .din  (set_req_raw),
        .rise (set_rise)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk  (clk),
        .rst  (rst),
        .din  (clr_req_raw),
        .rise (clr_rise)
    );

    // One-deep request flags; a new rise in the same cycle as the clear is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_s <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            pend_s <= (pend_s & ~clr_s) | set_rise;
            pend_r <= (pend_r & ~clr_r) | clr_rise;
        end
    end

    // State, selection and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= SEL_S;
            conf_q   <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            conf_q   <= conf_d;
            S        <= s_d;
            R        <= r_d;
            conflict <= conflict_d;
        end
    end

    // Hold-off timer runs only while in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state_q == HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // Next-state, side selection and pulse decode.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        conf_d     = conf_q;
        clr_s      = 1'b0;
        clr_r      = 1'b0;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_s || pend_r) begin
                    state_d = FIRE;
                    if (pend_s && pend_r) begin
                        sel_d  = PRIO_SEL;
                        conf_d = 1'b1;
                    end else begin
                        sel_d  = pend_r ? SEL_R : SEL_S;
                        conf_d = 1'b0;
                    end
                end
            end
            FIRE: begin
                s_d        = (sel_q == SEL_S);
                r_d        = (sel_q == SEL_R);
                conflict_d = conf_q;
                clr_s      = (sel_q == SEL_S);
                clr_r      = (sel_q == SEL_R);
                state_d    = HOLD;
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE) || pend_s || pend_r;

`ifdef SR_CONFLICT_CNT_EN
    // Saturating count of conflict pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= 8'd0;
        end else if (conflict && (conflict_cnt != 8'hFF)) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end
`endif

endmodule
